// File: rtl/timer_irq_master_if.sv
// ============================================================================
// Module   : timer_irq_master_if
// Purpose  : 16-bit Avalon-MM register bus between the timer master and slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface timer_irq_master_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );
endinterface

`default_nettype wire

// File: rtl/timer_irq_master.sv
// ============================================================================
// Module   : timer_irq_master
// Purpose  : CPU-less Avalon-MM master that programs the interval timer,
//            services its timeout interrupts and counts ticks.
//            Optional macro TIMER_IRQ_MASTER_SNAPSHOT_EN adds a counter
//            snapshot read after each serviced tick.
// Revision : 1.0
// ============================================================================
`default_nettype none

module timer_irq_master #(
  parameter bit CTRL_CONT = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [31:0]               period,
  output logic                      busy,
  output logic                      tick,
  output logic [15:0]               tick_count,
  output logic [31:0]               snapshot,
  timer_irq_master_if.master        bus
);

  localparam logic [2:0]  ADDR_STATUS = 3'd0;
  localparam logic [2:0]  ADDR_CTRL   = 3'd1;
  localparam logic [2:0]  ADDR_PER_L  = 3'd2;
  localparam logic [2:0]  ADDR_PER_H  = 3'd3;
  localparam logic [2:0]  ADDR_SNAP_L = 3'd4;
  localparam logic [2:0]  ADDR_SNAP_H = 3'd5;
  localparam logic [15:0] CTL_RUN     = CTRL_CONT ? 16'h0007 : 16'h0005;
  localparam logic [15:0] CTL_STOP    = 16'h0008;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_PL    = 4'd1,
    WR_PH    = 4'd2,
    WR_CTL   = 4'd3,
    WAIT_IRQ = 4'd4,
    CLR_ST   = 4'd5,
    WR_STOP  = 4'd6
`ifdef TIMER_IRQ_MASTER_SNAPSHOT_EN
    ,
    SNAP_WR  = 4'd7,
    RD_SL_A  = 4'd8,
    RD_SL_D  = 4'd9,
    RD_SH_A  = 4'd10,
    RD_SH_D  = 4'd11
`endif
  } state_t;

  state_t      state;
  state_t      state_nxt;
  state_t      after_service;
  logic [31:0] period_q;
  logic        stop_pending;
  logic        stop_req;
  logic        start_ok;

  assign stop_req = stop_pending | stop;
  assign start_ok = (state == IDLE) && start && !stop;

  // Where the service loop lands once the interrupt has been cleared.
  always_comb begin
    if (!CTRL_CONT)
      after_service = IDLE;
    else if (stop_req)
      after_service = WR_STOP;
    else
      after_service = WAIT_IRQ;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 16'h0000;
    busy           = (state != IDLE);
    tick           = 1'b0;

    case (state)
      IDLE: begin
        if (start_ok)
          state_nxt = WR_PL;
      end

      WR_PL: begin
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = ADDR_PER_L;
        bus.writedata  = period_q[15:0];
        state_nxt      = WR_PH;
      end

      WR_PH: begin
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = ADDR_PER_H;
        bus.writedata  = period_q[31:16];
        state_nxt      = WR_CTL;
      end

      WR_CTL: begin
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = ADDR_CTRL;
        bus.writedata  = CTL_RUN;
        state_nxt      = stop_req ? WR_STOP : WAIT_IRQ;
      end

      // A pending interrupt is serviced before a pending stop.
      WAIT_IRQ: begin
        if (bus.irq)
          state_nxt = CLR_ST;
        else if (stop_req)
          state_nxt = WR_STOP;
      end

      CLR_ST: begin
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = ADDR_STATUS;
        bus.writedata  = 16'h0000;
        tick           = 1'b1;
`ifdef TIMER_IRQ_MASTER_SNAPSHOT_EN
        state_nxt      = SNAP_WR;
`else
        state_nxt      = after_service;
`endif
      end

      WR_STOP: begin
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = ADDR_CTRL;
        bus.writedata  = CTL_STOP;
        state_nxt      = IDLE;
      end

`ifdef TIMER_IRQ_MASTER_SNAPSHOT_EN
      SNAP_WR: begin
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = ADDR_SNAP_L;
        state_nxt      = RD_SL_A;
      end

      RD_SL_A: begin
        bus.chipselect = 1'b1;
        bus.address    = ADDR_SNAP_L;
        state_nxt      = RD_SL_D;
      end

      RD_SL_D: begin
        bus.chipselect = 1'b1;
        bus.address    = ADDR_SNAP_L;
        state_nxt      = RD_SH_A;
      end

      RD_SH_A: begin
        bus.chipselect = 1'b1;
        bus.address    = ADDR_SNAP_H;
        state_nxt      = RD_SH_D;
      end

      RD_SH_D: begin
        bus.chipselect = 1'b1;
        bus.address    = ADDR_SNAP_H;
        state_nxt      = after_service;
      end
`endif

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q     <= 32'h0;
      tick_count   <= 16'h0;
      stop_pending <= 1'b0;
    end else begin
      if (start_ok) begin
        period_q   <= period;
        tick_count <= 16'h0;
      end else if (state == CLR_ST) begin
        tick_count <= tick_count + 16'h1;
      end

      // Any return to IDLE discards a leftover stop request.
      if (state_nxt == IDLE)
        stop_pending <= 1'b0;
      else if ((state != IDLE) && stop)
        stop_pending <= 1'b1;
    end
  end

`ifdef TIMER_IRQ_MASTER_SNAPSHOT_EN
  logic [15:0] snap_lo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_lo  <= 16'h0;
      snapshot <= 32'h0;
    end else begin
      if (state == RD_SL_D)
        snap_lo <= bus.readdata;
      if (state == RD_SH_D)
        snapshot <= {bus.readdata, snap_lo};
    end
  end
`else
  logic unused_readdata;

  assign unused_readdata = ^bus.readdata;
  assign snapshot        = 32'h0;
`endif

endmodule

`default_nettype wire
